collision_detect: RTL and testbench

- Consumes the per-pixel obstacle stream produced by the level generator and the player sprite stream produced by the character renderer.
- Decides once per video frame whether the player overlapped an obstacle.
- Reports a one-cycle hit pulse and a sticky collided flag to the game FSM, which uses them to enter FAIL1.
- Also keeps a saturating survived-frames counter, used as the score.

---
 rtl/collision_detect.sv | 143 ++++++++++++++
 tb/tb_collision_detect.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_detect.sv
// Per-frame player/obstacle overlap detector: grace period after start, consecutive
// hit-frame filtering, sticky collided flag and a saturating survived-frames score.
module collision_detect #(
  parameter int CIDXW        = 3,
  parameter int HMIN         = 170,
  parameter int HMAX         = 750,
  parameter int VMIN         = 34,
  parameter int VMAX         = 516,
  parameter int MIN_OVERLAP  = 4,
  parameter int HIT_FRAMES   = 2,
  parameter int GRACE_FRAMES = 30
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             pix_en,
  input  logic [9:0]       hc,
  input  logic [9:0]       vc,
  input  logic [3:0]       state,
  input  logic [CIDXW:0]   player_pix,
  input  logic [CIDXW:0]   obstacle_pix,
  output logic             hit,
  output logic             collided,
  output logic [15:0]      score,
  output logic             armed
);

  typedef enum logic [1:0] {S_IDLE, S_GRACE, S_ARMED, S_HIT} fsm_t;

  localparam logic [15:0] GRACE_LAST = 16'(GRACE_FRAMES - 1);
  localparam logic [7:0]  HIT_LAST   = 8'(HIT_FRAMES - 1);
  localparam logic [9:0]  MIN_OVL    = 10'(MIN_OVERLAP);

  fsm_t        fsm;
  logic [9:0]  ovl_cnt;
  logic [15:0] grace_cnt;
  logic [7:0]  hitrun_cnt;

  logic running;
  logic idle;
  logic marker;
  logic in_win;
  logic overlap;
  logic frame_hit;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign running   = (state >= 4'd5) && (state <= 4'd10);
  assign idle      = (state == 4'd11);
  assign marker    = (hc == 10'd0) && (vc == 10'd0);
  assign in_win    = (hc >= 10'(HMIN)) && (hc <= 10'(HMAX)) &&
                     (vc >= 10'(VMIN)) && (vc <= 10'(VMAX));
  assign overlap   = in_win && (player_pix != '0) && (obstacle_pix != '0);
  assign frame_hit = (ovl_cnt >= MIN_OVL);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fsm        <= S_IDLE;
      ovl_cnt    <= '0;
      grace_cnt  <= '0;
      hitrun_cnt <= '0;
      hit        <= 1'b0;
      collided   <= 1'b0;
      score      <= '0;
      armed      <= 1'b0;
    end else begin
      // hit is a single-CLK pulse regardless of the pixel strobe
      hit <= 1'b0;
      if (pix_en) begin
        if (idle) begin
          fsm        <= S_IDLE;
          armed      <= 1'b0;
          collided   <= 1'b0;
          score      <= '0;
          ovl_cnt    <= '0;
          hitrun_cnt <= '0;
          grace_cnt  <= '0;
        end else begin
          case (fsm)
            S_IDLE: begin
              ovl_cnt    <= '0;
              grace_cnt  <= '0;
              hitrun_cnt <= '0;
              if (running) begin
                if (GRACE_FRAMES == 0) begin
                  fsm   <= S_ARMED;
                  armed <= 1'b1;
                end else begin
                  fsm <= S_GRACE;
                end
              end
            end
            S_GRACE: begin
              if (running) begin
                if (marker) begin
                  ovl_cnt <= '0;
                  if (grace_cnt == GRACE_LAST) begin
                    fsm   <= S_ARMED;
                    armed <= 1'b1;
                  end else begin
                    grace_cnt <= grace_cnt + 16'd1;
                  end
                end else if (overlap) begin
                  ovl_cnt <= sat_inc10(ovl_cnt);
                end
              end
            end
            S_ARMED: begin
              if (running) begin
                if (marker) begin
                  ovl_cnt <= '0;
                  if (frame_hit) begin
                    hitrun_cnt <= hitrun_cnt + 8'd1;
                    if (hitrun_cnt == HIT_LAST) begin
                      fsm      <= S_HIT;
                      armed    <= 1'b0;
                      collided <= 1'b1;
                      hit      <= 1'b1;
                    end
                  end else begin
                    hitrun_cnt <= '0;
                    score      <= sat_inc16(score);
                  end
                end else if (overlap) begin
                  ovl_cnt <= sat_inc10(ovl_cnt);
                end
              end
            end
            default: begin
              // S_HIT: everything frozen until the game returns to idle
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_collision_detect.sv
// Directed bench for collision_detect with a frame-level reference model and a
// per-cycle output comparison.
module tb_collision_detect;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        pix_en = 1'b0;
  logic [9:0]  hc = '0;
  logic [9:0]  vc = 10'd5;
  logic [3:0]  state = 4'd0;
  logic [3:0]  player_pix = '0;
  logic [3:0]  obstacle_pix = '0;
  logic        hit;
  logic        collided;
  logic [15:0] score;
  logic        armed;

  collision_detect dut (
    .CLK(CLK), .RESET_N(RESET_N), .pix_en(pix_en), .hc(hc), .vc(vc),
    .state(state), .player_pix(player_pix), .obstacle_pix(obstacle_pix),
    .hit(hit), .collided(collided), .score(score), .armed(armed)
  );

  always #5 CLK = ~CLK;

  localparam int M_IDLE = 0, M_GRACE = 1, M_ARMED = 2, M_HIT = 3;
  localparam int GRACE = 30, NHIT = 2, MINOV = 4;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   hit_seen = 0;
  bit   chk_en = 0;
  logic [3:0] cur_state = 4'd0;

  // Reference model: what the outputs must be after the next active edge
  int   m_mode = M_IDLE;
  int   m_graced = 0;
  int   m_streak = 0;
  int   m_ovl = 0;
  int   m_score = 0;
  logic m_collided = 1'b0;
  logic m_hit = 1'b0;

  task automatic model_reset();
    m_mode = M_IDLE; m_graced = 0; m_streak = 0; m_ovl = 0;
    m_score = 0; m_collided = 1'b0; m_hit = 1'b0;
  endtask

  task automatic model_step();
    bit run, mark, counted;
    m_hit = 1'b0;
    if (!pix_en) return;
    run  = (state >= 4'd5 && state <= 4'd10);
    mark = (hc == 0 && vc == 0);
    counted = (hc >= 170 && hc <= 750 && vc >= 34 && vc <= 516 &&
               player_pix != 0 && obstacle_pix != 0);
    if (state == 4'd11) begin
      model_reset();
      return;
    end
    case (m_mode)
      M_IDLE: begin
        m_ovl = 0; m_graced = 0; m_streak = 0;
        if (run) m_mode = (GRACE == 0) ? M_ARMED : M_GRACE;
      end
      M_GRACE: if (run) begin
        if (mark) begin
          m_graced++;
          m_ovl = 0;
          if (m_graced == GRACE) m_mode = M_ARMED;
        end else if (counted) m_ovl = (m_ovl < 1023) ? m_ovl + 1 : 1023;
      end
      M_ARMED: if (run) begin
        if (mark) begin
          if (m_ovl >= MINOV) begin
            m_streak++;
            if (m_streak == NHIT) begin
              m_mode = M_HIT; m_collided = 1'b1; m_hit = 1'b1;
            end
          end else begin
            m_streak = 0;
            if (m_score < 65535) m_score++;
          end
          m_ovl = 0;
        end else if (counted) m_ovl = (m_ovl < 1023) ? m_ovl + 1 : 1023;
      end
      default: ;
    endcase
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      if (hit) hit_seen++;
      n_cmp += 4;
      if (hit !== m_hit) begin
        n_bad++; $display("FAIL hit: got %b expected %b at %0t", hit, m_hit, $time);
      end
      if (collided !== m_collided) begin
        n_bad++; $display("FAIL collided: got %b expected %b at %0t", collided, m_collided, $time);
      end
      if (score !== 16'(m_score)) begin
        n_bad++; $display("FAIL score: got %0d expected %0d at %0t", score, m_score, $time);
      end
      if (armed !== (m_mode == M_ARMED)) begin
        n_bad++; $display("FAIL armed: got %b expected %b at %0t", armed, (m_mode == M_ARMED), $time);
      end
    end
  end

  task automatic cyc(input logic en, input logic [9:0] h, input logic [9:0] v,
                     input logic [3:0] pp, input logic [3:0] op);
    @(negedge CLK); #1;
    pix_en = en; hc = h; vc = v; player_pix = pp; obstacle_pix = op;
    state = cur_state;
    model_step();
  endtask

  task automatic nop();    cyc(1'b1, 10'd5, 10'd5, 4'd0, 4'd0); endtask
  task automatic marker(); cyc(1'b1, 10'd0, 10'd0, 4'd0, 4'd0); endtask

  task automatic ovl_px(input int n);
    cyc(1'b0, 10'd300, 10'd200, 4'd2, 4'd7);   // strobe low: never counted
    cyc(1'b1, 10'd300, 10'd200, 4'd2, 4'd0);   // transparent obstacle
    for (int i = 0; i < n; i++) cyc(1'b1, 10'(200 + i), 10'd100, 4'd3, 4'd5);
  endtask

  task automatic markers(input int n);
    for (int i = 0; i < n; i++) marker();
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_hit", hit, 0); chk("rst_collided", collided, 0);
    chk("rst_score", score, 0); chk("rst_armed", armed, 0);
    @(negedge CLK); #1 RESET_N = 1'b1;
    chk_en = 1;

    // Continuous overlap from the first frame: grace suppresses, then collision
    cur_state = 4'd5;
    nop();
    for (int f = 0; f < GRACE; f++) begin marker(); ovl_px(10); end
    nop();
    chk("armed_after_grace", armed, 1);
    chk("no_hit_in_grace", hit_seen, 0);
    marker(); ovl_px(10);
    marker();
    nop();
    chk("hit_pulses", hit_seen, 1);
    chk("collided_set", collided, 1);
    chk("score_at_hit", score, 0);
    chk("model_collided", m_collided, 1);

    // FAIL1 holds everything, idle clears on the marker cycle without evaluating
    cur_state = 4'd12;
    for (int f = 0; f < 5; f++) begin marker(); ovl_px(6); end
    nop();
    chk("collided_held_fail", collided, 1);
    cur_state = 4'd11;
    marker();
    nop();
    chk("collided_clear_idle", collided, 0);
    chk("hit_once_total", hit_seen, 1);

    // Alternating hit/clean frames with a paused grace period
    cur_state = 4'd5;
    nop();
    markers(10);
    cur_state = 4'd12; markers(3);
    cur_state = 4'd5;  markers(19);
    nop();
    chk("armed_late", armed, 0);
    marker();
    nop();
    chk("armed_after_pause", armed, 1);
    for (int f = 0; f < 50; f++) begin
      if (f % 2 == 0) ovl_px(5);
      marker();
    end
    nop();
    chk("alt_score", score, 25);
    chk("alt_model_score", m_score, 25);
    chk("alt_collided", collided, 0);
    cur_state = 4'd12; markers(2);
    nop();
    chk("score_hold_nonrun", score, 25);
    cur_state = 4'd11; nop();
    nop();
    chk("score_clear_idle", score, 0);

    // Sub-threshold overlap plus out-of-window pixels, then in-window edges
    cur_state = 4'd5;
    nop();
    markers(GRACE);
    for (int f = 0; f < 100; f++) begin
      ovl_px(3);
      cyc(1'b1, 10'd169, 10'd100, 4'd1, 4'd1);
      cyc(1'b1, 10'd751, 10'd100, 4'd1, 4'd1);
      cyc(1'b1, 10'd200, 10'd33,  4'd1, 4'd1);
      cyc(1'b1, 10'd200, 10'd517, 4'd1, 4'd1);
      marker();
    end
    nop();
    chk("sub_thr_score", score, 100);
    chk("sub_thr_collided", collided, 0);
    cyc(1'b1, 10'd170, 10'd100, 4'd1, 4'd1);
    cyc(1'b1, 10'd750, 10'd100, 4'd1, 4'd1);
    cyc(1'b1, 10'd200, 10'd34,  4'd1, 4'd1);
    cyc(1'b1, 10'd200, 10'd516, 4'd1, 4'd1);
    marker();
    marker();
    nop();
    chk("edge_frame_is_hit", score, 101);

    // Asynchronous reset mid-frame with a partial overlap count
    ovl_px(7);
    #2 RESET_N = 1'b0;
    model_reset();
    #1;
    chk("async_hit", hit, 0); chk("async_collided", collided, 0);
    chk("async_score", score, 0); chk("async_armed", armed, 0);
    @(negedge CLK); #1 RESET_N = 1'b1;

    // Score saturation
    nop();
    markers(GRACE);
    markers(65534);
    nop();
    chk("score_fffe", score, 16'hFFFE);
    markers(3);
    nop();
    chk("score_sat", score, 16'hFFFF);
    chk("model_score_sat", m_score, 65535);
    chk("hit_once_final", hit_seen, 1);

    nop();
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
